eq_coeff_loader: RTL and testbench
==================================

# eq_coeff_loader

Coefficient sweep engine that drives the equalizer's per-bin coefficient write port (`coeff_wr_en` / `coeff_index` / `coeff_in`). Software writes a small table of per-band gains. A `start` pulse then makes the block expand that table into `SAMPLES` per-bin coefficients, one write per cycle. The expansion mirrors across the FFT midpoint so that bins k and SAMPLES-k always receive the same coefficient. The block sits between the host register interface and the equalizer.

## Interface
- `SAMPLES`, 2048: FFT length and number of coefficient writes per sweep; power of 2.
- `BANDS`, 16: number of host-programmable band gains; power of 2, at most SAMPLES/2.
- `COEFF_BITS`, 8: coefficient width, unsigned.
- `COEFF_FRACTION_BITS`, 5: fraction bits; unity is `1<<COEFF_FRACTION_BITS` (0x20).

Ports (BW = SAMPLES/2/BANDS):
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `gain_wr_en`  in  1  writes `gain_in` into the gain table at `gain_index`.
- `gain_index`  in  $clog2(BANDS)  band to write.
- `gain_in`  in  COEFF_BITS  band gain, unsigned fixed point.
- `start`  in  1  begins a sweep; sampled only in IDLE.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse at the end of a sweep.
- `coeff_wr_en`  out  1  coefficient write strobe to the equalizer.
- `coeff_index`  out  $clog2(SAMPLES)  bin being written.
- `coeff_in`  out  COEFF_BITS  coefficient value.

## Operation
- Reset values:
  - Gain table: every entry 0x20 (unity).
  - All outputs 0.
  - FSM in IDLE.
- FSM states:
  - IDLE → SWEEP on `start`.
  - SWEEP → DONE after bin counter SAMPLES-1 has been issued and the pipeline has drained.
  - DONE → IDLE unconditionally, after one cycle.
- Gain writes:
  - Accepted in IDLE and DONE.
  - Ignored while `busy`=1, so one sweep never mixes old and new gains.
- `start` while `busy` is ignored.
- Bin k is issued in ascending order, 0..SAMPLES-1. Folded index: f = k for k ≤ SAMPLES/2, else f = SAMPLES-k.
- band b = f / BW, clamped to BANDS-1. Only f = SAMPLES/2 needs the clamp.
- Coefficient, piecewise-constant mode: `coeff_in` = gain[b].
- Divisions by BW are shifts; all arithmetic is unsigned.
- Output is written each bin; the equalizer saturates downstream. This block never saturates or wraps.

## Timing
- Pipeline: stage 0 bin counter and fold → stage 1 registered gain lookup → stage 2 registered arithmetic and outputs. All outputs are registered.
- Cycle numbering: edge E0 samples `start`=1 in IDLE.
  - After E0: `busy`=1.
  - After E2: first `coeff_wr_en`=1 with `coeff_index`=0.
  - Writes then come back-to-back, exactly SAMPLES of them with no gaps; index SAMPLES-1 appears after E(SAMPLES+1).
  - After E(SAMPLES+2): `coeff_wr_en`=0, `busy`=0, `done`=1.
  - After E(SAMPLES+3): `done`=0, state IDLE, a new `start` is accepted.
- Gain writes are visible to a sweep started on the next edge.
- Reset mid-sweep:
  - `coeff_wr_en` drops asynchronously and no further writes are issued.
  - The gain table returns to unity.
  - `done` is not pulsed.
  - The equalizer keeps any partial coefficients until it is reset or re-swept.

## Configuration
- `EQ_LINEAR_INTERP_EN` defined:
  - p = f mod BW.
  - coeff = (gain[b]·(BW-p) + gain[b+1]·p) >> log2(BW), truncated. gain[BANDS] is taken as gain[BANDS-1].
  - Intermediate width is COEFF_BITS+log2(BW)+1. The result never exceeds max(gain[b], gain[b+1]), so it fits COEFF_BITS.
  - Latency is unchanged: the multiply-add sits in stage 2.
- `EQ_LINEAR_INTERP_EN` undefined: piecewise-constant mode as in Operation. The stage-2 register remains, so latency is identical.

## Test plan
- Reset, `start` with no gain writes → 2048 writes, indices 0..2047 ascending, every `coeff_in`=0x20. First write after E2, `done` after E2050, exactly one `done` pulse.
- Piecewise mode, gain[0]=0x40, gain[15]=0x10:
  - bins 0..63 and 1985..2047 → 0x40.
  - bin 64 → 0x20.
  - bins 960..1024 and 1024..1088 → 0x10.
  - bin 1984 → 0x20.
- `EQ_LINEAR_INTERP_EN`, gain[0]=0x00, gain[1]=0x40 → bin 16 → 0x10, bin 32 → 0x20, bin 63 → 0x3F, bin 64 → 0x40, bin 2032 → 0x10.
- During a sweep, pulse `start` and write gain[0]=0x80 → still exactly 2048 writes with unchanged values; the next sweep shows 0x80 in bins 0..63.
- `EQ_LINEAR_INTERP_EN`, all gains 0xFF → every `coeff_in`=0xFF, no wrap.
- Assert `rst` when `coeff_index`=500 → `coeff_wr_en` low before the next edge, no `done`. After release, `start` yields all-0x20 writes.

Source files
------------

// File: rtl/eq_coeff_loader.sv
// Equalizer coefficient sweep engine: expands a per-band gain table into SAMPLES mirrored per-bin writes.
// Optional linear interpolation between bands is enabled by defining EQ_LINEAR_INTERP_EN.
module eq_coeff_loader #(
  parameter int SAMPLES             = 2048,
  parameter int BANDS               = 16,
  parameter int COEFF_BITS          = 8,
  parameter int COEFF_FRACTION_BITS = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       gain_wr_en,
  input  logic [$clog2(BANDS)-1:0]   gain_index,
  input  logic [COEFF_BITS-1:0]      gain_in,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       coeff_wr_en,
  output logic [$clog2(SAMPLES)-1:0] coeff_index,
  output logic [COEFF_BITS-1:0]      coeff_in
);

  localparam int IDX_W  = $clog2(SAMPLES);
  localparam int BAND_W = $clog2(BANDS);
  localparam int BW     = SAMPLES / 2 / BANDS;
  localparam int LOG_BW = $clog2(BW);
  localparam int FB_W   = IDX_W - LOG_BW;
  localparam logic [IDX_W-1:0]      LAST_K = IDX_W'(SAMPLES - 1);
  localparam logic [IDX_W-1:0]      HALF_K = IDX_W'(SAMPLES / 2);
  localparam logic [BAND_W-1:0]     TOP_B  = BAND_W'(BANDS - 1);
  localparam logic [COEFF_BITS-1:0] UNITY  = COEFF_BITS'(1 << COEFF_FRACTION_BITS);

`ifdef EQ_LINEAR_INTERP_EN
  localparam int P_W   = (LOG_BW > 0) ? LOG_BW : 1;
  localparam int ACC_W = COEFF_BITS + LOG_BW + 1;
  localparam logic [P_W:0] BW_L = (P_W + 1)'(BW);

  // Weighted blend of two neighbouring band gains; the result is bounded by the larger gain.
  function automatic logic [COEFF_BITS-1:0] lerp(input logic [COEFF_BITS-1:0] g0,
                                                 input logic [COEFF_BITS-1:0] g1,
                                                 input logic [P_W-1:0]        p);
    logic [ACC_W-1:0] acc;
    acc = ACC_W'(g0) * ACC_W'(BW_L - {1'b0, p}) + ACC_W'(g1) * ACC_W'({1'b0, p});
    return COEFF_BITS'(acc >> LOG_BW);
  endfunction
`endif

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;
  state_t state_q, state_d;

  logic [COEFF_BITS-1:0] gain_tbl [BANDS];

  logic             vld_p0;
  logic [IDX_W-1:0] k_p0;
  logic [IDX_W-1:0] f_p0;
  logic [FB_W-1:0]  band_raw_p0;
  logic [BAND_W-1:0] band_p0;

  logic                  vld_p1;
  logic [IDX_W-1:0]      k_p1;
  logic [COEFF_BITS-1:0] g0_p1;
`ifdef EQ_LINEAR_INTERP_EN
  logic [BAND_W-1:0]     band_nx_p0;
  logic [P_W-1:0]        p_p0;
  logic [P_W-1:0]        p_p1;
  logic [COEFF_BITS-1:0] g1_p1;
`endif

  wire sweep_go  = (state_q == S_IDLE) && start;
  wire last_out  = coeff_wr_en && (coeff_index == LAST_K);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == S_SWEEP);
      done    <= (state_d == S_DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SWEEP;
      S_SWEEP: if (last_out) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Gains are frozen while busy so a sweep never mixes two tables.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BANDS; i++) gain_tbl[i] <= UNITY;
    end else if (gain_wr_en && !busy) begin
      gain_tbl[gain_index] <= gain_in;
    end
  end

  // ---- stage 0: bin counter and fold ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            vld_p0 <= 1'b0;
    else if (sweep_go)                  vld_p0 <= 1'b1;
    else if (vld_p0 && (k_p0 == LAST_K)) vld_p0 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (sweep_go)    k_p0 <= '0;
    else if (vld_p0) k_p0 <= k_p0 + 1'b1;
  end

  // SAMPLES-k modulo 2^IDX_W is simply -k.
  always_comb begin
    f_p0        = (k_p0 <= HALF_K) ? k_p0 : (~k_p0 + 1'b1);
    band_raw_p0 = f_p0[IDX_W-1:LOG_BW];
    band_p0     = (band_raw_p0 >= FB_W'(BANDS)) ? TOP_B : band_raw_p0[BAND_W-1:0];
`ifdef EQ_LINEAR_INTERP_EN
    band_nx_p0  = (band_p0 == TOP_B) ? band_p0 : band_p0 + 1'b1;
    p_p0        = (LOG_BW > 0) ? f_p0[P_W-1:0] : '0;
`endif
  end

  // ---- stage 1: gain lookup ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    k_p1  <= k_p0;
    g0_p1 <= gain_tbl[band_p0];
`ifdef EQ_LINEAR_INTERP_EN
    g1_p1 <= gain_tbl[band_nx_p0];
    p_p1  <= p_p0;
`endif
  end

  // ---- stage 2: coefficient arithmetic and registered outputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coeff_wr_en <= 1'b0;
      coeff_index <= '0;
      coeff_in    <= '0;
    end else begin
      coeff_wr_en <= vld_p1;
      if (vld_p1) begin
        coeff_index <= k_p1;
`ifdef EQ_LINEAR_INTERP_EN
        coeff_in    <= lerp(g0_p1, g1_p1, p_p1);
`else
        coeff_in    <= g0_p1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_eq_coeff_loader.sv
// Self-checking bench for eq_coeff_loader: random gain tables swept and compared bin-by-bin
// against a table-expansion reference model; honours EQ_LINEAR_INTERP_EN like the design.
module tb_eq_coeff_loader;

  localparam int SAMPLES = 2048;
  localparam int BANDS   = 16;
  localparam int BW      = SAMPLES / 2 / BANDS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gain_wr_en = 1'b0;
  logic [3:0]  gain_index = '0;
  logic [7:0]  gain_in = '0;
  logic        start = 1'b0;
  logic        busy, done, coeff_wr_en;
  logic [10:0] coeff_index;
  logic [7:0]  coeff_in;

  int n_assert = 0;
  int n_fail   = 0;
  int model_gain [BANDS];
  int cap [SAMPLES];
  int nw, nd;

  eq_coeff_loader dut (
    .clk(clk), .rst(rst),
    .gain_wr_en(gain_wr_en), .gain_index(gain_index), .gain_in(gain_in),
    .start(start), .busy(busy), .done(done),
    .coeff_wr_en(coeff_wr_en), .coeff_index(coeff_index), .coeff_in(coeff_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("%s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_coeff(input int k);
    int f, b, bn, p;
    f  = (k <= SAMPLES / 2) ? k : SAMPLES - k;
    b  = f / BW;
    if (b > BANDS - 1) b = BANDS - 1;
`ifdef EQ_LINEAR_INTERP_EN
    bn = (b + 1 > BANDS - 1) ? BANDS - 1 : b + 1;
    p  = f % BW;
    return (model_gain[b] * (BW - p) + model_gain[bn] * p) / BW;
`else
    bn = 0; p = 0;
    return model_gain[b];
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < BANDS; i++) model_gain[i] = 32;
  endtask

  task automatic write_gain(input int idx, input int val);
    @(negedge clk);
    gain_wr_en = 1'b1; gain_index = 4'(idx); gain_in = 8'(val);
    @(posedge clk);
    #1 gain_wr_en = 1'b0;
    model_gain[idx] = val;
  endtask

  // Runs one sweep and checks every cycle against the documented timing.
  task automatic sweep(input int disturb_c, input bit rst_at_500, input bit done_poke,
                       output int writes, output int dones);
    int pk_idx, pk_val;
    writes = 0; dones = 0;
    pk_idx = 0; pk_val = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= SAMPLES + 8; c++) begin
      @(negedge clk);
      start = 1'b0; gain_wr_en = 1'b0;
      check("wr_en", int'(coeff_wr_en), int'(c >= 2 && c <= SAMPLES + 1));
      check("busy", int'(busy), int'(c <= SAMPLES + 1));
      check("done", int'(done), int'(c == SAMPLES + 2));
      if (done) dones++;
      if (coeff_wr_en) begin
        writes++;
        if (c >= 2 && c <= SAMPLES + 1) begin
          check("index", int'(coeff_index), c - 2);
          check("coeff", int'(coeff_in), exp_coeff(c - 2));
          cap[c - 2] = int'(coeff_in);
        end
      end
      if (rst_at_500 && c == 502) begin
        #2 rst = 1'b1;
        #1;
        check("rst_wr_en", int'(coeff_wr_en), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_index", int'(coeff_index), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (c == disturb_c) begin
        start = 1'b1; gain_wr_en = 1'b1; gain_index = 4'd0; gain_in = 8'h80;
      end
      if (done_poke && c == SAMPLES + 2) begin
        pk_idx = $urandom_range(BANDS - 1);
        pk_val = $urandom_range(255);
        start = 1'b1; gain_wr_en = 1'b1; gain_index = 4'(pk_idx); gain_in = 8'(pk_val);
      end
      if (done_poke && c == SAMPLES + 3) model_gain[pk_idx] = pk_val;
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_wr_en", int'(coeff_wr_en), 0);
    check("reset_index", int'(coeff_index), 0);
    check("reset_coeff", int'(coeff_in), 0);
    rst = 1'b0;

    // Default table: all unity.
    sweep(-1, 1'b0, 1'b0, nw, nd);
    check("unity_writes", nw, SAMPLES);
    check("unity_dones", nd, 1);
    check("unity_bin1024", cap[1024], 32);

`ifdef EQ_LINEAR_INTERP_EN
    write_gain(0, 8'h00);
    write_gain(1, 8'h40);
    sweep(-1, 1'b0, 1'b0, nw, nd);
    check("lin_bin16", cap[16], 8'h10);
    check("lin_bin32", cap[32], 8'h20);
    check("lin_bin63", cap[63], 8'h3F);
    check("lin_bin64", cap[64], 8'h40);
    check("lin_bin2032", cap[2032], 8'h10);
    write_gain(0, 8'h20);
    write_gain(1, 8'h20);
`else
    write_gain(0, 8'h40);
    write_gain(15, 8'h10);
    sweep(-1, 1'b0, 1'b0, nw, nd);
    check("pw_bin0", cap[0], 8'h40);
    check("pw_bin63", cap[63], 8'h40);
    check("pw_bin64", cap[64], 8'h20);
    check("pw_bin960", cap[960], 8'h10);
    check("pw_bin1024", cap[1024], 8'h10);
    check("pw_bin1088", cap[1088], 8'h10);
    check("pw_bin1984", cap[1984], 8'h20);
    check("pw_bin1985", cap[1985], 8'h40);
    check("pw_bin2047", cap[2047], 8'h40);
`endif

    // Random table; mid-sweep start and gain write must be ignored; DONE accepts a write.
    for (int i = 0; i < BANDS; i++) write_gain(i, $urandom_range(255));
    sweep(100, 1'b0, 1'b1, nw, nd);
    check("dist_writes", nw, SAMPLES);
    check("dist_dones", nd, 1);
    sweep(-1, 1'b0, 1'b0, nw, nd);
    check("post_done_writes", nw, SAMPLES);

    write_gain(0, 8'h80);
    sweep(-1, 1'b0, 1'b0, nw, nd);
    check("g80_bin0", cap[0], 8'h80);

    for (int i = 0; i < BANDS; i++) write_gain(i, 8'hFF);
    sweep(-1, 1'b0, 1'b0, nw, nd);
    check("ff_bin40", cap[40], 8'hFF);
    check("ff_bin1000", cap[1000], 8'hFF);

    // Reset mid-sweep, then the table must be back to unity.
    for (int i = 0; i < BANDS; i++) write_gain(i, $urandom_range(255));
    sweep(-1, 1'b1, 1'b0, nw, nd);
    check("rst_sweep_dones", nd, 0);
    repeat (2) @(negedge clk);
    check("after_rst_busy", int'(busy), 0);
    check("after_rst_done", int'(done), 0);
    sweep(-1, 1'b0, 1'b0, nw, nd);
    check("after_rst_writes", nw, SAMPLES);
    check("after_rst_bin777", cap[777], 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
